// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: scans up/down call slots and routes each pending call to the cheapest lift.
// Optional DISPATCH_STATS_EN adds saturating assignment/reassignment counters.
//
// slot state | meaning
// S_IDLE     | no call outstanding
// S_PEND     | call latched, waiting for the scan pointer and an eligible lift
// S_ASGN     | routed to r_owner, waiting for the lift to acknowledge and serve it
module hall_call_dispatcher #(
   parameter int N_FLOORS    = 12,
   parameter int N_LIFTS     = 10,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_FLOORS-1:0]           up_rqst,
   input  logic [N_FLOORS-1:0]           dn_rqst,
   input  logic [N_LIFTS*N_FLOORS-1:0]   floor_sense,
   input  logic [N_LIFTS-1:0]            motion,
   input  logic [N_LIFTS-1:0]            direction,
   input  logic [N_LIFTS-1:0]            in_service,
   input  logic [N_LIFTS*N_FLOORS-1:0]   up_rqst_status,
   input  logic [N_LIFTS*N_FLOORS-1:0]   dn_rqst_status,
   output logic [N_LIFTS*N_FLOORS-1:0]   up_assign,
   output logic [N_LIFTS*N_FLOORS-1:0]   dn_assign,
   output logic [N_FLOORS-1:0]           global_up_rqst_status,
   output logic [N_FLOORS-1:0]           global_dn_rqst_status
`ifdef DISPATCH_STATS_EN
   ,output logic [15:0]                  assign_count,
   output logic [15:0]                   reassign_count
`endif
);

   localparam int NS = 2 * N_FLOORS;
   localparam int FW = $clog2(N_FLOORS);
   localparam int LW = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1;
   localparam int PW = $clog2(NS);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_ASGN} slot_t;

   slot_t            r_state [NS];
   logic [LW-1:0]    r_owner [NS];
   logic [NS-1:0]    r_seen;
   logic [CW-1:0]    r_cnt   [NS];
   logic [PW-1:0]    r_ptr;
   logic [FW-1:0]    r_last  [N_LIFTS];

   slot_t            w_state [NS];
   logic [LW-1:0]    w_owner [NS];
   logic [NS-1:0]    w_seen;
   logic [CW-1:0]    w_cnt   [NS];
   logic [CW-1:0]    w_cnt_inc;
   logic [N_LIFTS*N_FLOORS-1:0] w_up_assign, w_dn_assign;
   logic [N_FLOORS-1:0]         w_gup, w_gdn;

   logic             w_up, w_found, w_ok, w_req, w_stat;
   logic [LW-1:0]    w_best;
   int               w_f, w_cur, w_diff, w_cost, w_best_cost, w_sf, w_bit;

`ifdef DISPATCH_STATS_EN
   logic             w_asg_evt;
   logic [15:0]      w_ret_evt;
   logic [16:0]      w_re_sum;
   assign w_re_sum = {1'b0, reassign_count} + {1'b0, w_ret_evt};
`endif

   // Lift selection for the slot under the scan pointer; strict < keeps the lowest index on ties.
   always_comb begin
      w_up        = (r_ptr < PW'(N_FLOORS));
      w_f         = w_up ? int'(r_ptr) : int'(r_ptr) - N_FLOORS;
      w_found     = 1'b0;
      w_best      = '0;
      w_best_cost = 0;
      w_cur       = 0;
      w_diff      = 0;
      w_cost      = 0;
      w_ok        = 1'b0;
      for (int l = 0; l < N_LIFTS; l++) begin
         w_cur  = int'(r_last[l]);
         w_diff = (w_f >= w_cur) ? (w_f - w_cur) : (w_cur - w_f);
         w_ok   = 1'b0;
         w_cost = 0;
         if (in_service[l]) begin
            if (!motion[l]) begin
               w_ok   = 1'b1;
               w_cost = w_diff + N_FLOORS;
            end else if ((direction[l] == w_up) && (w_up ? (w_cur <= w_f) : (w_cur >= w_f))) begin
               w_ok   = 1'b1;
               w_cost = w_diff;
            end
         end
         if (w_ok && (!w_found || (w_cost < w_best_cost))) begin
            w_found     = 1'b1;
            w_best      = LW'(l);
            w_best_cost = w_cost;
         end
      end
   end

   always_comb begin
      w_seen      = r_seen;
      w_sf        = 0;
      w_bit       = 0;
      w_req       = 1'b0;
      w_stat      = 1'b0;
      w_cnt_inc   = '0;
      w_up_assign = '0;
      w_dn_assign = '0;
      w_gup       = '0;
      w_gdn       = '0;
`ifdef DISPATCH_STATS_EN
      w_asg_evt   = 1'b0;
      w_ret_evt   = '0;
`endif
      for (int s = 0; s < NS; s++) begin
         w_state[s] = r_state[s];
         w_owner[s] = r_owner[s];
         w_cnt[s]   = r_cnt[s];
      end
      for (int s = 0; s < NS; s++) begin
         w_sf      = (s < N_FLOORS) ? s : s - N_FLOORS;
         w_req     = (s < N_FLOORS) ? up_rqst[w_sf] : dn_rqst[w_sf];
         w_bit     = int'(r_owner[s]) * N_FLOORS + w_sf;
         w_stat    = (s < N_FLOORS) ? up_rqst_status[w_bit] : dn_rqst_status[w_bit];
         w_cnt_inc = r_cnt[s] + CW'(1);
         case (r_state[s])
            S_IDLE: if (w_req) w_state[s] = S_PEND;
            S_PEND: begin
               if ((PW'(s) == r_ptr) && w_found) begin
                  w_state[s] = S_ASGN;
                  w_owner[s] = w_best;
                  w_seen[s]  = 1'b0;
                  w_cnt[s]   = '0;
`ifdef DISPATCH_STATS_EN
                  w_asg_evt  = 1'b1;
`endif
               end
            end
            S_ASGN: begin
               if (!in_service[r_owner[s]]) begin
                  w_state[s] = S_PEND;
                  w_seen[s]  = 1'b0;
                  w_cnt[s]   = '0;
`ifdef DISPATCH_STATS_EN
                  w_ret_evt  = w_ret_evt + 16'd1;
`endif
               end else if (r_seen[s]) begin
                  if (!w_stat) begin
                     w_state[s] = S_IDLE;
                     w_seen[s]  = 1'b0;
                  end
               end else if (w_stat) begin
                  w_seen[s] = 1'b1;
               end else if (w_cnt_inc == CW'(ACK_TIMEOUT)) begin
                  w_state[s] = S_PEND;
                  w_cnt[s]   = '0;
`ifdef DISPATCH_STATS_EN
                  w_ret_evt  = w_ret_evt + 16'd1;
`endif
               end else begin
                  w_cnt[s] = w_cnt_inc;
               end
            end
            default: w_state[s] = S_IDLE;
         endcase
         // Outputs are decoded from next state so the registered copies match the slot flops.
         w_bit = int'(w_owner[s]) * N_FLOORS + w_sf;
         if (w_state[s] != S_IDLE) begin
            if (s < N_FLOORS) w_gup[w_sf] = 1'b1;
            else              w_gdn[w_sf] = 1'b1;
         end
         if (w_state[s] == S_ASGN) begin
            if (s < N_FLOORS) w_up_assign[w_bit] = 1'b1;
            else              w_dn_assign[w_bit] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NS; s++) begin
            r_state[s] <= S_IDLE;
            r_owner[s] <= '0;
            r_cnt[s]   <= '0;
         end
         r_seen                <= '0;
         r_ptr                 <= '0;
         for (int l = 0; l < N_LIFTS; l++) r_last[l] <= '0;
         up_assign             <= '0;
         dn_assign             <= '0;
         global_up_rqst_status <= '0;
         global_dn_rqst_status <= '0;
`ifdef DISPATCH_STATS_EN
         assign_count          <= '0;
         reassign_count        <= '0;
`endif
      end else begin
         for (int s = 0; s < NS; s++) begin
            r_state[s] <= w_state[s];
            r_owner[s] <= w_owner[s];
            r_cnt[s]   <= w_cnt[s];
         end
         r_seen <= w_seen;
         r_ptr  <= (r_ptr == PW'(NS - 1)) ? '0 : r_ptr + PW'(1);
         for (int l = 0; l < N_LIFTS; l++)
            for (int f = 0; f < N_FLOORS; f++)
               if (floor_sense[l*N_FLOORS + f]) r_last[l] <= FW'(f);
         up_assign             <= w_up_assign;
         dn_assign             <= w_dn_assign;
         global_up_rqst_status <= w_gup;
         global_dn_rqst_status <= w_gdn;
`ifdef DISPATCH_STATS_EN
         if (w_asg_evt && (assign_count != 16'hFFFF)) assign_count <= assign_count + 16'd1;
         reassign_count <= w_re_sum[16] ? 16'hFFFF : w_re_sum[15:0];
`endif
      end
   end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher with 4 floors, 2 lifts, timeout 8.
module tb_hall_call_dispatcher;
   localparam int NF = 4;
   localparam int NL = 2;
   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NF-1:0]    up_rqst, dn_rqst;
   logic [NL*NF-1:0] floor_sense, up_rqst_status, dn_rqst_status;
   logic [NL-1:0]    motion, direction, in_service;
   logic [NL*NF-1:0] up_assign, dn_assign;
   logic [NF-1:0]    gup, gdn;
`ifdef DISPATCH_STATS_EN
   logic [15:0]      assign_count, reassign_count;
`endif

   int checks   = 0;
   int failures = 0;
   int n;
   int hold;

   hall_call_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .up_rqst(up_rqst), .dn_rqst(dn_rqst),
      .floor_sense(floor_sense), .motion(motion), .direction(direction),
      .in_service(in_service), .up_rqst_status(up_rqst_status),
      .dn_rqst_status(dn_rqst_status), .up_assign(up_assign), .dn_assign(dn_assign),
      .global_up_rqst_status(gup), .global_dn_rqst_status(gdn)
`ifdef DISPATCH_STATS_EN
      ,.assign_count(assign_count), .reassign_count(reassign_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NF-1:0] u, input logic [NF-1:0] d);
      up_rqst = u;
      dn_rqst = d;
      tick();
      up_rqst = '0;
      dn_rqst = '0;
   endtask

   task automatic wait_assign(output int lat);
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if ((up_assign | dn_assign) != '0) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic serve(input int b, input logic is_dn);
      if (is_dn) dn_rqst_status[b] = 1'b1;
      else       up_rqst_status[b] = 1'b1;
      tick();
      tick();
      dn_rqst_status = '0;
      up_rqst_status = '0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      up_rqst        = '0;
      dn_rqst        = '0;
      floor_sense    = 8'h11;
      motion         = '0;
      direction      = '0;
      in_service     = 2'b11;
      up_rqst_status = '0;
      dn_rqst_status = '0;
      repeat (3) tick();
      check_eq("rst_up_assign", up_assign, 0);
      check_eq("rst_gup", gup, 0);
      reset_n = 1'b1;

      // both stopped at 0: lift 0 wins the tie
      tick();
      pulse(4'b0100, 4'b0000);
      wait_assign(n);
      check_eq("lat_first", (n >= 1 && n <= 9), 1);
      check_eq("first_up_assign", up_assign, 8'h04);
      check_eq("first_gup", gup, 4'b0100);
      serve(2, 1'b0);
      check_eq("served_gup", gup, 0);
      check_eq("served_assign", up_assign, 0);

      pulse(4'b0100, 4'b0000);
      check_eq("repeat_accepted", gup, 4'b0100);
      wait_assign(n);
      check_eq("repeat_assign", up_assign, 8'h04);

      // no status from the lift: assignment times out after TO cycles
      hold = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (up_assign[2]) hold++;
         else break;
      end
      check_eq("timeout_hold", hold, TO);
      check_eq("timeout_pending", gup, 4'b0100);
      wait_assign(n);
      check_eq("lat_reassign", (n >= 1 && n <= 9), 1);
      check_eq("reassign_lift0", up_assign, 8'h04);
`ifdef DISPATCH_STATS_EN
      check_eq("assign_count", assign_count, 3);
      check_eq("reassign_count", reassign_count, 1);
`endif

      // owner goes out of service
      in_service = 2'b10;
      tick();
      check_eq("oos_drop", up_assign, 0);
      check_eq("oos_pending", gup, 4'b0100);
      wait_assign(n);
      check_eq("oos_move_lift1", up_assign, 8'h40);
      serve(6, 1'b0);
      check_eq("oos_served", gup, 0);
      in_service = 2'b11;

      // lift 1 moving up from floor 1
      floor_sense = 8'b0010_0001;
      motion      = 2'b10;
      direction   = 2'b10;
      tick();
      tick();
      pulse(4'b1000, 4'b0000);
      wait_assign(n);
      check_eq("moving_cheaper", up_assign, 8'h80);
      serve(7, 1'b0);
      pulse(4'b0001, 4'b0000);
      wait_assign(n);
      check_eq("passed_inelig", up_assign, 8'h01);
      serve(0, 1'b0);
      pulse(4'b0000, 4'b0010);
      wait_assign(n);
      check_eq("dn_wrong_dir", dn_assign, 8'h02);
      serve(1, 1'b1);
      check_eq("dn_served", gdn, 0);

      // nobody in service: calls stay pending
      in_service = 2'b00;
      pulse(4'b0011, 4'b0001);
      repeat (12) tick();
      check_eq("noelig_up", up_assign, 0);
      check_eq("noelig_dn", dn_assign, 0);
      check_eq("noelig_gup", gup, 4'b0011);
      check_eq("noelig_gdn", gdn, 4'b0001);

      // async reset mid-cycle
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_up", up_assign, 0);
      check_eq("arst_dn", dn_assign, 0);
      check_eq("arst_gup", gup, 0);
      check_eq("arst_gdn", gdn, 0);
`ifdef DISPATCH_STATS_EN
      check_eq("arst_counts", {assign_count, reassign_count}, 0);
`endif
      in_service  = 2'b11;
      motion      = '0;
      direction   = '0;
      floor_sense = 8'h11;
      up_rqst     = 4'b0010;
      tick();
      reset_n = 1'b1;
      tick();
      up_rqst = '0;
      check_eq("post_rst_pend", gup, 4'b0010);
      check_eq("post_rst_noasg", up_assign, 0);
      tick();
      check_eq("ptr_restart", up_assign, 8'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hall_call_dispatcher.md
HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

Interface
REQ-001 The block SHALL have parameter N_FLOORS, default 12, meaning number of floors (>=2).
REQ-002 The block SHALL have parameter N_LIFTS, default 10, meaning number of lift cars (>=1).
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 64, meaning cycles an assigned call may wait before its status bit rises.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port up_rqst, input, N_FLOORS bits: hall up-call pulses or levels, one bit per floor.
REQ-007 The block SHALL have port dn_rqst, input, N_FLOORS bits: hall down-call pulses or levels.
REQ-008 The block SHALL have port floor_sense, input, N_LIFTS*N_FLOORS bits: per-lift one-hot floor, all zero between floors; lift l occupies bits [l*N_FLOORS +: N_FLOORS].
REQ-009 The block SHALL have ports motion, direction and in_service, each input, N_LIFTS bits: car moving; 1=up; car available.
REQ-010 The block SHALL have ports up_rqst_status and dn_rqst_status, each input, N_LIFTS*N_FLOORS bits: the lift's latched call status.
REQ-011 The block SHALL have ports up_assign and dn_assign, each output, N_LIFTS*N_FLOORS bits: registered per-lift call routing.
REQ-012 The block SHALL have ports global_up_rqst_status and global_dn_rqst_status, each output, N_FLOORS bits: a slot is non-IDLE.

Function
REQ-013 The block SHALL keep 2*N_FLOORS call slots (up f, down f), each with state IDLE, PENDING or ASSIGNED, owner index, seen flag and timeout counter.
REQ-014 An IDLE slot SHALL go PENDING on the cycle after its request bit is sampled high; a request to a non-IDLE slot SHALL be ignored.
REQ-015 A scan pointer SHALL visit one slot per cycle (up 0..N_FLOORS-1, then down 0..N_FLOORS-1) and wrap to 0 after the last slot.
REQ-016 A PENDING slot under the pointer SHALL pick the cheapest eligible lift and go ASSIGNED on the next edge; max call-to-assign latency is 2*N_FLOORS+1 cycles.
REQ-017 Cost SHALL use last_floor (last non-zero floor_sense, binary): a moving same-direction lift not yet past f costs |f-cur|; a stopped lift costs |f-cur|+N_FLOORS; any other lift is ineligible.
REQ-018 Ties SHALL go to the lowest lift index; lifts with in_service=0 SHALL be ineligible; with no eligible lift the slot SHALL remain PENDING (no fallback).
REQ-019 An ASSIGNED slot SHALL drive exactly its owner's up_assign/dn_assign bit high, held until the slot leaves ASSIGNED.
REQ-020 The owner's status bit seen high SHALL set seen; seen=1 followed by the status bit low SHALL return the slot to IDLE (call served).
REQ-021 With seen=0 the counter SHALL increment each cycle; on reaching ACK_TIMEOUT the slot SHALL return to PENDING and the counter SHALL clear.
REQ-022 The owner's in_service falling SHALL return an ASSIGNED slot to PENDING on the next edge, regardless of seen.
REQ-023 Arithmetic SHALL use $clog2 widths: counter $clog2(ACK_TIMEOUT+1), owner $clog2(N_LIFTS) (min 1), pointer $clog2(2*N_FLOORS).

Reset
REQ-024 Asserting reset_n low SHALL immediately set every slot IDLE, clear seen, counters and owners, and set pointer to 0.
REQ-025 Reset SHALL set last_floor to floor 0 and drive every output to zero; reset mid-assignment SHALL drop that call with no recovery.
REQ-026 The first scan after reset_n deasserts SHALL occur on the first rising clk edge.

Configuration
REQ-027 With macro DISPATCH_STATS_EN defined, the block SHALL add outputs assign_count and reassign_count, each 16 bits, incrementing on every assignment and every timeout or out-of-service return, saturating at 0xFFFF and cleared by reset.
REQ-028 Without DISPATCH_STATS_EN, those ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Verification
Scenarios use N_FLOORS=4, N_LIFTS=2, ACK_TIMEOUT=8.
REQ-029 Both lifts stopped at floor 0, up_rqst[2] pulsed -> up_assign[2] (lift 0) high within 9 cycles; lift 1 is never assigned.
REQ-030 Lift 1 moving up from floor 1, lift 0 stopped at 0, up_rqst[3] -> lift 1 assigned with cost 2 versus 7.
REQ-031 Assigned lift never raises status -> the slot returns to PENDING after 8 cycles, is reassigned, and reassign_count=1 when DISPATCH_STATS_EN is defined.
REQ-032 Owner's in_service dropped while ASSIGNED -> the assign bit falls the next cycle and the call moves to the other lift.
REQ-033 Status rises then falls -> the slot goes IDLE, global status bit clears, and a repeated up_rqst is accepted again.
REQ-034 reset_n pulsed low mid-scan with 3 PENDING slots -> all outputs 0 immediately and pointer restarts at 0.
